// File: rtl/fpu_lzc_pkg.sv
// Shared types and helpers for the sequential leading-zero counter / normalizer.
package fpu_lzc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } lzc_state_e;

  // Bits needed to hold a zero count in the range 0..w.
  function automatic int lzc_cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_norm_seq_nlc_4bit.sv
// Nibble leading-zero counter: count of leading zeros in a 4-bit nibble plus an all-zero flag.
module NLC_4bit (
  input  logic [3:0] i_nib,
  output logic [1:0] o_zero,
  output logic       o_all_zero
);

  // Priority encode from the MSB; o_zero is don't-care (0) when the nibble is all zero.
  always_comb begin
    o_zero     = 2'd0;
    o_all_zero = 1'b0;
    if (i_nib[3]) begin
      o_zero = 2'd0;
    end else if (i_nib[2]) begin
      o_zero = 2'd1;
    end else if (i_nib[1]) begin
      o_zero = 2'd2;
    end else if (i_nib[0]) begin
      o_zero = 2'd3;
    end else begin
      o_all_zero = 1'b1;
    end
  end

endmodule

// File: rtl/lzc_norm_seq.sv
// Multi-cycle leading-zero counter and normalizer for FPU mantissas.
// Scans the captured operand one nibble per cycle (MSB nibble first) through one
// shared NLC_4bit, then left-shifts the operand by the resulting zero count.
module lzc_norm_seq
  import fpu_lzc_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [WIDTH-1:0]                   i_mant,
  input  logic                               i_abort,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [fpu_lzc_pkg::lzc_cnt_w(WIDTH)-1:0] o_lz,
  output logic [WIDTH-1:0]                   o_norm,
  output logic                               o_all_zero,
  output logic                               o_busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = lzc_cnt_w(WIDTH);
  localparam int K_W   = (NIB > 1) ? $clog2(NIB) : 1;

  lzc_state_e       r_state;
  logic [WIDTH-1:0] r_op;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_lz;
  logic [WIDTH-1:0] r_norm;
  logic             r_all_zero;

  logic [3:0]       w_nib;
  logic [1:0]       w_zero;
  logic             w_nib_zero;
  logic             w_last;
  logic             w_accept;
  logic [CNT_W-1:0] w_lz_cand;
  logic [WIDTH-1:0] w_shifted;

  // Abort in IDLE suppresses ready so it wins over a simultaneous request.
  assign o_ready    = (r_state == IDLE) && !i_abort;
  assign w_accept   = i_valid && o_ready;
  assign o_valid    = (r_state == DONE);
  assign o_busy     = (r_state != IDLE);
  assign o_lz       = r_lz;
  assign o_norm     = r_norm;
  assign o_all_zero = r_all_zero;

  assign w_last     = (r_k == K_W'(NIB - 1));
  // 4k + Zero peaks at WIDTH-1 here, so CNT_W bits never overflow.
  assign w_lz_cand  = (CNT_W'(r_k) << 2) + CNT_W'(w_zero);
  // A shift of WIDTH pushes every bit out and yields zero.
  assign w_shifted  = r_op << r_lz;

  // Select nibble k of the operand, k = 0 being the most significant nibble.
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (r_k == K_W'(i)) begin
        w_nib = r_op[WIDTH-1-4*i -: 4];
      end
    end
  end

  NLC_4bit u_nlc (
    .i_nib      (w_nib),
    .o_zero     (w_zero),
    .o_all_zero (w_nib_zero)
  );

  // FSM plus result registers; reset and abort both drop the operation and clear results.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_abort) begin
      r_state    <= IDLE;
      r_lz       <= '0;
      r_norm     <= '0;
      r_all_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (!w_nib_zero) begin
            r_lz       <= w_lz_cand;
            r_all_zero <= 1'b0;
            r_state    <= SHIFT;
          end else if (w_last) begin
            r_lz       <= CNT_W'(WIDTH);
            r_all_zero <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_norm  <= w_shifted;
          r_state <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand capture and nibble index; only meaningful while the FSM is busy, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op <= i_mant;
      r_k  <= '0;
    end else if ((r_state == SCAN) && w_nib_zero && !w_last) begin
      r_k <= r_k + 1'b1;
    end
  end

endmodule
